dm_responder: RTL
=================

# dm_responder

Multi-cycle data-memory responder: the memory-side end of the datapath's load/store interface. It accepts one byte/half/word load or store per valid/ready request, spends a fixed configurable latency accessing an internal word-organised array, then returns read data and an error flag over a valid/ready response channel. It replaces the single-cycle data memory when the core moves to a stalling memory interface.

## Interface
- `ADDR_WIDTH`, default 10: log2 of the word count. Byte capacity is 4·2^ADDR_WIDTH.
- `LATENCY`, default 2: cycles from request accept to response valid. Legal range is 1..15.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_signed`  in  1  loads only: 1 sign-extends, 0 zero-extends.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  32  load result, extended. 0 for stores and errors.
- `rsp_err`  out  1  misaligned, illegal-size or out-of-range request.

## Operation
- FSM states: IDLE, WAIT, RESP.
- `req_ready` = (state == IDLE). `rsp_valid` = (state == RESP).
- Accept: on a rising edge where `req_valid` and `req_ready` are both 1:
  - latch `we`, `size`, `signed`, `addr` and `wdata`;
  - load cnt with LATENCY−1;
  - move to WAIT.
- WAIT:
  - if cnt ≠ 0, decrement cnt;
  - if cnt == 0, perform the access and move to RESP.
- The access happens on the WAIT→RESP edge:
  - Error check:
    - size 11;
    - half access with addr[0] = 1;
    - word access with addr[1:0] ≠ 0;
    - addr[31:ADDR_WIDTH+2] ≠ 0.
  - Error: no memory write; `rsp_rdata` = 0; `rsp_err` = 1.
  - Store: little-endian byte lanes.
    - Byte: wdata[7:0] goes to lane addr[1:0].
    - Half: wdata[15:0] goes to lanes {addr[1],1'b1} and {addr[1],1'b0}.
    - Word: writes all four lanes.
    - Lanes not written keep their value. `rsp_rdata` = 0; `rsp_err` = 0.
  - Load: select the addressed lane(s), then extend to 32 bits per the latched `signed` bit. `rsp_err` = 0.
- RESP:
  - `rsp_rdata` and `rsp_err` hold stable until handshake;
  - on an edge with `rsp_ready` = 1, move to IDLE.
- There is one outstanding request at most. A new request cannot be accepted in the RESP→IDLE edge.
- The memory array is word-addressed by addr[ADDR_WIDTH+1:2] and cleared to 0 on reset.

## Timing
- Reset (`reset` low, async):
  - state = IDLE, cnt = 0, memory all 0;
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0;
  - `req_ready` reads 1, but no request is accepted while `reset` is low.
- Reset mid-operation:
  - the pending request is dropped;
  - no write occurs unless it already completed on a prior WAIT→RESP edge;
  - outputs return to reset values immediately, without waiting for a clock edge.
- Latency: accept at edge t gives `rsp_valid` = 1 after edge t+LATENCY. Memory is updated at that same edge.
- Throughput:
  - with `rsp_ready` tied 1, one request every LATENCY+2 cycles;
  - the next accept is earliest at edge t+LATENCY+2.
- Back-pressure: `rsp_ready` low holds RESP indefinitely. Outputs do not change, and `req_ready` stays 0.
- Request inputs are sampled only at the accept edge. Changes to them during WAIT or RESP have no effect.
- Store-then-load to the same address returns the stored data. There are no hazards inside the block.

## Test plan
All scenarios use ADDR_WIDTH = 10 and LATENCY = 2.
1. Store word 0x12345678 to 0x10, then load word from 0x10 → `rsp_valid` high two edges after each accept, `rsp_rdata` = 0x12345678, `rsp_err` = 0.
2. Store byte 0xAB to 0x13, then:
   - load word 0x10 → 0xAB345678;
   - load signed byte 0x13 → 0xFFFFFFAB;
   - load unsigned byte 0x13 → 0x000000AB.
3. Store half 0x8001 to 0x12, then:
   - load word 0x10 → 0x80015678;
   - load signed half 0x12 → 0xFFFF8001;
   - load unsigned half 0x12 → 0x00008001.
4. Error requests:
   - store word to 0x11 → `rsp_err` = 1, `rsp_rdata` = 0;
   - load word 0x10 afterwards still returns 0x80015678;
   - load word 0x1000 → `rsp_err` = 1;
   - size 11 → `rsp_err` = 1.
5. Back-pressure: hold `rsp_ready` = 0 for 5 cycles while `req_valid` = 1 with a second request:
   - `rsp_valid`, `rsp_rdata` and `rsp_err` stay stable;
   - `req_ready` stays 0 and the second request is not accepted;
   - raise `rsp_ready` → IDLE after one edge, then the second request is accepted on the following edge.
6. Reset mid-operation: accept store word 0xFFFFFFFF to 0x20 and pull `reset` low one cycle later →
   - `rsp_valid` drops to 0 at once;
   - after release, load word 0x20 → 0x00000000 and `rsp_err` = 0.

Source files
------------

// File: rtl/dm_responder.sv
// dm_responder: multi-cycle data-memory responder.
// Accepts one byte/half/word load or store per request handshake, waits a
// fixed LATENCY, performs the access on the WAIT->RESP edge and holds the
// response until the consumer takes it. At most one request is in flight.
module dm_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_BAD = 2'b11} size_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    we_q;
  size_t                   size_q;
  logic                    signed_q;
  logic [31:0]             addr_q;
  logic [31:0]             wdata_q;
  logic [31:0]             rdata_q;
  logic                    err_q;
  logic [31:0]             mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0]   idx;
  logic [31:0]             rd_word;
  logic [15:0]             lane_data;
  logic [31:0]             ld_data;
  logic [31:0]             wr_rep;
  logic [31:0]             wr_word;
  logic [3:0]              wr_mask;
  logic                    acc_err;

  assign idx     = addr_q[ADDR_WIDTH+1:2];
  assign rd_word = mem_q[idx];

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Decode the latched request: error check, load extraction and store merge.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    acc_err   = (addr_q[31:ADDR_WIDTH+2] != '0);
    lane_data = 16'(rd_word >> {addr_q[1:0], 3'b000});
    ld_data   = rd_word;
    wr_mask   = 4'b1111;
    wr_rep    = wdata_q;
    wr_word   = rd_word;
    case (size_q)
      SZ_BYTE: begin
        ld_data = signed_q ? {{24{lane_data[7]}}, lane_data[7:0]} : {24'h0, lane_data[7:0]};
        wr_mask = 4'b0001 << addr_q[1:0];
        wr_rep  = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        acc_err = acc_err | addr_q[0];
        ld_data = signed_q ? {{16{lane_data[15]}}, lane_data} : {16'h0, lane_data};
        wr_mask = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_rep  = {2{wdata_q[15:0]}};
      end
      SZ_WORD: acc_err = acc_err | (addr_q[1:0] != 2'b00);
      default: acc_err = 1'b1;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (wr_mask[i]) wr_word[8*i +: 8] = wr_rep[8*i +: 8];
    end
  end

  // Request/response FSM with registered response and the memory array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      // NOTE: the array is architecturally cleared by reset, so it cannot map to a plain RAM macro.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            size_q   <= size_t'(req_size);
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            cnt_q    <= CNT_INIT;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= RESP;
            err_q   <= acc_err;
            rdata_q <= (acc_err || we_q) ? 32'h0 : ld_data;
            if (!acc_err && we_q) mem_q[idx] <= wr_word;
          end
        end
        RESP: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
